tdm_bus_ctrl: RTL and testbench
===============================

Name: tdm_bus_ctrl

Overview:
- Bus master for the 4-mic TDM array: generates the bit clock (sck) and frame-sync (ws) that drive the microphones and the tdm_receive deserializer.
- Also publishes per-bit strobes and slot/bit position on the system clock, so downstream logic can stay in the clk_in domain.
- Handles start/stop sequencing: the bus only ever stops on a frame boundary, and an optional startup-mute flag gates out mic warm-up frames.

Parameters:
- SCK_HALF_PERIOD, 16, clk_in cycles per sck half-period (sck = clk_in / 32); must be >= 2.
- SLOT_BITS, 32, sck cycles per TDM slot.
- SLOTS, 4, slots per frame.
- STARTUP_FRAMES, 64, frames muted after start (used only with TDM_STARTUP_MUTE_EN).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- enable_in  input  1  level request; high = run bus.
- sck_out  output  1  TDM serial clock to mics and receiver.
- ws_out  output  1  TDM word select / frame sync.
- sck_rise_out  output  1  1-clk strobe, first clk cycle with sck_out=1.
- sck_fall_out  output  1  1-clk strobe, first clk cycle with sck_out=0 after a high phase.
- frame_start_out  output  1  1-clk strobe when position becomes slot 0, bit 0.
- slot_out  output  $clog2(SLOTS)  current slot index.
- bit_out  output  $clog2(SLOT_BITS)  current bit index within slot.
- busy_out  output  1  high in RUN and STOPPING.
- mics_ready_out  output  1  audio-valid gate (see Optional Feature).

Behaviour:
- Reset: rst_in=1 asynchronously clears all state and outputs to 0, with state = IDLE. It takes effect mid-frame without completing the frame.
- Outputs: all outputs are registered; no combinational paths from inputs.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - sck_out=0, ws_out=0, strobes=0, slot/bit=0, busy_out=0.
  - enable_in sampled high at cycle N -> RUN at N+1.
- RUN entry (cycle N+1):
  - div_cnt=0, sck_out=0.
  - slot_out=SLOTS-1, bit_out=SLOT_BITS-1, ws_out=1. This makes the first sck period a lead-in with ws high.
- Divider:
  - div_cnt counts 0..SCK_HALF_PERIOD-1; on the terminal count sck_out toggles and div_cnt wraps to 0.
  - First sck rise is at N+1+SCK_HALF_PERIOD.
- Position advance:
  - Only on sck falling edges, in the same cycle sck_fall_out is high.
  - bit_out increments. At SLOT_BITS-1 it wraps to 0 and slot_out increments; at SLOTS-1 slot_out wraps to 0.
  - The wrap to slot 0 / bit 0 raises frame_start_out.
- ws timing:
  - ws_out changes only on sck falling edges.
  - It is high for exactly one sck period: the one carrying slot SLOTS-1, bit SLOT_BITS-1. It is therefore seen high on exactly one sck rising edge, immediately before bit 0 of slot 0.
- Frame length: SLOTS*SLOT_BITS*2*SCK_HALF_PERIOD clk cycles (4096 at defaults).
- RUN -> STOPPING: enable_in=0 sampled in RUN.
- STOPPING:
  - The bus keeps clocking to the end of the current frame.
  - The final-bit ws pulse is suppressed (ws_out stays 0).
  - At the sck falling edge that would wrap to slot 0 / bit 0: go to IDLE. frame_start_out is not raised, sck_out=0, and slot/bit/busy are cleared that cycle.
- STOPPING -> RUN: enable_in=1 sampled in STOPPING returns to RUN with no change to sck or position cadence. The normal ws pulse is restored if the return happens before the final-bit falling edge.
- Simultaneous events: if enable_in falls in the same cycle as a final-bit falling edge in RUN, ws_out is still asserted for that bit (decision made on registered state), and the bus stops at the end of the following frame.
- Disable timing: enable_in toggling shorter than one clk cycle is not required to be seen.

Optional Feature:
- Macro: TDM_STARTUP_MUTE_EN.
- Defined:
  - A saturating frame counter is cleared in IDLE and increments on each frame_start_out.
  - mics_ready_out=0 until the frame_start_out pulse number STARTUP_FRAMES+1. It rises in that same cycle, stays high until IDLE, and goes low in the cycle IDLE is entered.
  - STARTUP_FRAMES=0 gives ready at the first frame_start.
  - Re-enable from STOPPING does not re-mute.
- Undefined: no counter; mics_ready_out equals busy_out cycle-for-cycle.

Test Plan:
- Parameters for all scenarios: SCK_HALF_PERIOD=2, SLOT_BITS=32, SLOTS=4, STARTUP_FRAMES=2.
- Enable sampled at cycle 10:
  - busy_out/ws_out=1 at 11, sck_rise_out at 13, sck_fall_out+frame_start_out at 15.
  - ws_out=0 at 15; slot_out=0, bit_out=0 at 15.
- Free-run 3 frames:
  - frame_start_out period = 512 clks; 128 sck_rise_out per frame.
  - ws_out high exactly 4 clks ending at each frame_start.
  - Feeding sck/ws to tdm_receive with a serialized pattern 0xA5A5A5, 0x123456, 0xFFFFFF, 0x000001 yields those words on audio_out1..4 with audio_valid_out pulsing once per frame.
- Drop enable_in at slot 1, bit 5:
  - Clocking continues to end of frame, no ws pulse on the final bit.
  - IDLE on the final falling edge: busy_out=0, sck_out=0, no frame_start_out.
- Drop enable_in then raise it again 100 clks later (still STOPPING): no gap in sck, ws pulse present, next frame_start exactly 512 clks after the previous.
- Assert rst_in asynchronously mid-slot 2: all outputs 0 before the next clk edge. After release with enable_in=1, the startup sequence repeats as in the enable-at-cycle-10 scenario.
- Startup mute:
  - With TDM_STARTUP_MUTE_EN: mics_ready_out rises with the 3rd frame_start_out and falls on entering IDLE.
  - Without the macro: mics_ready_out tracks busy_out exactly.

Source files
------------

// File: rtl/tdm_bus_ctrl.sv
// tdm_bus_ctrl: bus master for the 4-mic TDM array.
//
// Generates the TDM bit clock (sck) and frame sync (ws). It also publishes the
// sck edge strobes and the slot/bit position on clk_in, so downstream logic can
// stay in the system clock domain. The bus starts with a one-sck lead-in period
// carrying ws, and only ever stops on a frame boundary.
//
// Optional feature: define TDM_STARTUP_MUTE_EN to hold mics_ready_out low for
// the first STARTUP_FRAMES frames after start, which gates out mic warm-up
// frames. Without the macro, mics_ready_out follows busy_out.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   enable_in       level request, high = run the bus
//   sck_out         TDM serial clock
//   ws_out          TDM word select / frame sync
//   sck_rise_out    strobe, first clk cycle with sck_out=1
//   sck_fall_out    strobe, first clk cycle with sck_out=0 after a high phase
//   frame_start_out strobe when the position becomes slot 0, bit 0
//   slot_out        current slot index
//   bit_out         current bit index within the slot
//   busy_out        high while running or stopping
//   mics_ready_out  audio-valid gate
module tdm_bus_ctrl #(
    parameter int unsigned SCK_HALF_PERIOD = 16,
    parameter int unsigned SLOT_BITS       = 32,
    parameter int unsigned SLOTS           = 4,
    parameter int unsigned STARTUP_FRAMES  = 64
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable_in,
    output logic                         sck_out,
    output logic                         ws_out,
    output logic                         sck_rise_out,
    output logic                         sck_fall_out,
    output logic                         frame_start_out,
    output logic [$clog2(SLOTS)-1:0]     slot_out,
    output logic [$clog2(SLOT_BITS)-1:0] bit_out,
    output logic                         busy_out,
    output logic                         mics_ready_out
);

    localparam int unsigned SW = $clog2(SLOTS);
    localparam int unsigned BW = $clog2(SLOT_BITS);
    localparam int unsigned DW = $clog2(SCK_HALF_PERIOD);

    localparam logic [DW-1:0] DIV_LAST  = DW'(SCK_HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

    logic [1:0]    r_state, w_state;
    logic [DW-1:0] r_div, w_div;
    logic          r_sck, w_sck;
    logic          r_ws, w_ws;
    logic          r_rise, w_rise;
    logic          r_fall, w_fall;
    logic          r_fs, w_fs;
    logic [SW-1:0] r_slot, w_slot;
    logic [BW-1:0] r_bit, w_bit;
    logic          r_busy, w_busy;
    logic          r_ready, w_ready;

    logic          w_tc;
    logic          w_fall_edge;
    logic          w_bit_last;
    logic          w_slot_last;
    logic          w_wrap;
    logic [BW-1:0] w_bit_adv;
    logic [SW-1:0] w_slot_adv;
    logic          w_final_next;

    always_comb begin
        w_tc         = (r_div == DIV_LAST);
        w_fall_edge  = w_tc && r_sck;
        w_bit_last   = (r_bit == BIT_LAST);
        w_slot_last  = (r_slot == SLOT_LAST);
        w_wrap       = w_fall_edge && w_bit_last && w_slot_last;
        w_bit_adv    = w_bit_last ? '0 : r_bit + BW'(1);
        w_slot_adv   = !w_bit_last ? r_slot : (w_slot_last ? '0 : r_slot + SW'(1));
        w_final_next = (w_bit_adv == BIT_LAST) && (w_slot_adv == SLOT_LAST);
    end

    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_sck   = r_sck;
        w_ws    = r_ws;
        w_rise  = 1'b0;
        w_fall  = 1'b0;
        w_fs    = 1'b0;
        w_slot  = r_slot;
        w_bit   = r_bit;
        case (r_state)
            ST_IDLE: begin
                w_div  = '0;
                w_sck  = 1'b0;
                w_ws   = 1'b0;
                w_slot = '0;
                w_bit  = '0;
                if (enable_in) begin
                    // Park on the last bit so the first sck period is a lead-in with ws high.
                    w_state = ST_RUN;
                    w_slot  = SLOT_LAST;
                    w_bit   = BIT_LAST;
                    w_ws    = 1'b1;
                end
            end
            ST_RUN, ST_STOPPING: begin
                // A stop request only ends the bus at a wrap whose ws pulse was suppressed;
                // a pulse already on the wire means that frame must still be clocked out.
                if (r_state == ST_STOPPING && w_wrap && !r_ws) begin
                    w_state = ST_IDLE;
                    w_div   = '0;
                    w_sck   = 1'b0;
                    w_ws    = 1'b0;
                    w_slot  = '0;
                    w_bit   = '0;
                end else begin
                    w_state = enable_in ? ST_RUN : ST_STOPPING;
                    if (w_tc) begin
                        w_div  = '0;
                        w_sck  = ~r_sck;
                        w_rise = ~r_sck;
                        w_fall = r_sck;
                        if (r_sck) begin
                            w_bit  = w_bit_adv;
                            w_slot = w_slot_adv;
                            w_fs   = w_wrap;
                            // ws decision uses the registered state, not the live enable.
                            w_ws   = w_final_next && (r_state == ST_RUN);
                        end
                    end else begin
                        w_div = r_div + DW'(1);
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
        w_busy = (w_state != ST_IDLE);
    end

`ifdef TDM_STARTUP_MUTE_EN
    localparam int unsigned FW = $clog2(STARTUP_FRAMES + 2);
    localparam logic [FW-1:0] FRAMES_LAST = FW'(STARTUP_FRAMES);

    logic [FW-1:0] r_frame_cnt, w_frame_cnt;

    // Saturating count of frame starts since leaving IDLE.
    always_comb begin
        w_frame_cnt = r_frame_cnt;
        if (!w_busy) begin
            w_frame_cnt = '0;
        end else if (w_fs && r_frame_cnt != FRAMES_LAST) begin
            w_frame_cnt = r_frame_cnt + FW'(1);
        end
        w_ready = w_busy && (r_ready || (w_fs && r_frame_cnt == FRAMES_LAST));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= w_frame_cnt;
        end
    end
`else
    always_comb begin
        w_ready = w_busy;
    end
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_sck   <= 1'b0;
            r_ws    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_fs    <= 1'b0;
            r_slot  <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_sck   <= w_sck;
            r_ws    <= w_ws;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
            r_fs    <= w_fs;
            r_slot  <= w_slot;
            r_bit   <= w_bit;
            r_busy  <= w_busy;
            r_ready <= w_ready;
        end
    end

    assign sck_out         = r_sck;
    assign ws_out          = r_ws;
    assign sck_rise_out    = r_rise;
    assign sck_fall_out    = r_fall;
    assign frame_start_out = r_fs;
    assign slot_out        = r_slot;
    assign bit_out         = r_bit;
    assign busy_out        = r_busy;
    assign mics_ready_out  = r_ready;

endmodule

// File: tb/tb_tdm_bus_ctrl.sv
// tb_tdm_bus_ctrl: scoreboard bench for tdm_bus_ctrl.
// A reference model derives every output from the elapsed time since the bus
// started (sck phase and bit position by division/modulo) and pushes the
// expected output vector per cycle; a monitor pops and compares each cycle.
module tb_tdm_bus_ctrl;

    localparam int H  = 2;
    localparam int SB = 32;
    localparam int NS = 4;
    localparam int SF = 2;
    localparam int FB = SB * NS;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       sck, ws, rise, fall, fs, busy, ready;
    logic [1:0] slot;
    logic [4:0] bitp;

    tdm_bus_ctrl #(
        .SCK_HALF_PERIOD(H),
        .SLOT_BITS      (SB),
        .SLOTS          (NS),
        .STARTUP_FRAMES (SF)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .enable_in      (enable),
        .sck_out        (sck),
        .ws_out         (ws),
        .sck_rise_out   (rise),
        .sck_fall_out   (fall),
        .frame_start_out(fs),
        .slot_out       (slot),
        .bit_out        (bitp),
        .busy_out       (busy),
        .mics_ready_out (ready)
    );

    logic [13:0] act;
    assign act = {sck, ws, rise, fall, fs, slot, bitp, busy, ready};

    int n_vec = 0;
    int n_err = 0;

    logic [13:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    bit m_run   = 0;
    bit m_req   = 0;  // enable as seen at the previous edge
    bit m_ws_on = 0;  // whether the current/last final-bit ws pulse is issued
    int m_t     = 0;
    int m_frames = 0;

    function automatic logic [13:0] pack(input bit s, input bit w, input bit r, input bit f,
                                         input bit st, input int sl, input int bi,
                                         input bit bz, input bit rd);
        logic [1:0] sl2;
        logic [4:0] bi5;
        sl2 = sl[1:0];
        bi5 = bi[4:0];
        return {s, w, r, f, st, sl2, bi5, bz, rd};
    endfunction

    function automatic bit model_ready(input bit running, input int frames);
`ifdef TDM_STARTUP_MUTE_EN
        return running && (frames >= SF + 1);
`else
        return running;
`endif
    endfunction

    always @(posedge clk) begin
        logic [13:0] e;
        bit s, edg, r, f, st;
        int pos;
        e = '0;
        if (rst) begin
            m_run = 0;
        end else if (!m_run) begin
            if (enable) begin
                m_run = 1; m_t = 0; m_req = 1; m_ws_on = 1; m_frames = 0;
                e = pack(0, 1, 0, 0, 0, NS - 1, SB - 1, 1, model_ready(1, 0));
            end
        end else begin
            m_t++;
            s   = ((m_t / H) % 2) == 1;
            edg = (m_t % H) == 0;
            r   = edg && s;
            f   = edg && !s;
            pos = ((m_t / (2 * H)) + FB - 1) % FB;
            st  = 0;
            if (f && pos == FB - 1) m_ws_on = m_req;
            if (f && pos == 0) begin
                if (!m_req && !m_ws_on) m_run = 0;
                else begin st = 1; m_frames++; end
            end
            if (m_run)
                e = pack(s, (pos == FB - 1) && m_ws_on, r, f, st, pos / SB, pos % SB, 1,
                         model_ready(1, m_frames));
            m_req = enable;
        end
        exp_q.push_back(e);
    end

    // Monitor: one comparison per clock, sampled away from the edge.
    always @(posedge clk) begin
        logic [13:0] e;
        #1;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty t=%0t got=%b want=<entry>", $time, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t got=%b want=%b (sck ws rise fall fs slot bit busy rdy)",
                         $time, act, e);
            end
        end
    end

    task automatic wait_pos(input int s, input int b, input string name);
        int k;
        k = 0;
        while (!(slot == 2'(s) && bitp == 5'(b)) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout got slot=%0d bit=%0d want slot=%0d bit=%0d",
                     name, slot, bitp, s, b);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 6000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 6000) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout got busy=%0b want busy=0", name, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Start and free-run three frames.
        enable = 1'b1;
        repeat (3 * 512 + 20) @(negedge clk);

        // Drop enable mid-frame: must finish the frame without a final ws pulse.
        wait_pos(1, 5, "wait_slot1_bit5");
        enable = 1'b0;
        wait_idle("stop_after_drop");
        repeat (7) @(negedge clk);

        // Drop then re-enable within the same frame.
        enable = 1'b1;
        repeat (600) @(negedge clk);
        enable = 1'b0;
        repeat (100) @(negedge clk);
        enable = 1'b1;
        repeat (700) @(negedge clk);

        // Enable falls in the same cycle as the final-bit falling edge.
        wait_pos(3, 30, "wait_slot3_bit30");
        repeat (3) @(negedge clk);
        enable = 1'b0;
        wait_idle("stop_after_final_bit_drop");
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-slot 2, then restart.
        enable = 1'b1;
        wait_pos(2, 7, "wait_slot2");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if (act !== 14'd0) begin
            n_err++;
            $display("FAIL async_reset got=%b want=%b", act, 14'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (1200) @(negedge clk);

        // Random enable segments, including short pulses.
        for (int i = 0; i < 25; i++) begin
            int n;
            enable = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) n = $urandom_range(1, 6);
            else n = $urandom_range(20, 1500);
            repeat (n) @(negedge clk);
        end
        enable = 1'b0;
        wait_idle("final_stop");
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
